// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and status controller for an externally stored FIFO.
// Optional registered almost_full/almost_empty flags are built when FIFO_ALMOST_FLAGS_EN is defined.
module fifo_ctrl #(
  parameter int addr_width = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [addr_width-1:0] w_addr,
  output logic [addr_width-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  // Request semantics: wr/rd are single-cycle requests sampled on each rising edge.
  // A write is accepted when not full, or when full with a simultaneous read; a read
  // is accepted only when not empty. Rejected requests set the sticky error flags.

  localparam logic [addr_width:0]   DEPTH   = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0]   CNT_ONE = (addr_width + 1)'(1);
  localparam logic [addr_width-1:0] PTR_ONE = addr_width'(1);

  logic [addr_width-1:0] w_addr_q, w_addr_d;
  logic [addr_width-1:0] r_addr_q, r_addr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  do_write, do_read;

  always_comb begin
    do_write    = wr & (~full_q | rd);
    do_read     = rd & ~empty_q;
    w_addr_d    = w_addr_q;
    r_addr_d    = r_addr_q;
    count_d     = count_q;
    if (do_write) w_addr_d = w_addr_q + PTR_ONE;
    if (do_read)  r_addr_d = r_addr_q + PTR_ONE;
    case ({do_write, do_read})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Flags come from occupancy because the pointers coincide when full and when empty.
    full_d      = (count_d == DEPTH);
    empty_d     = (count_d == '0);
    overflow_d  = overflow_q | (wr & full_q & ~rd);
    underflow_d = underflow_q | (rd & empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_addr_q    <= '0;
      r_addr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_addr_q    <= w_addr_d;
      r_addr_q    <= r_addr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign w_en      = do_write;
  assign w_addr    = w_addr_q;
  assign r_addr    = r_addr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [addr_width:0] AF_LVL = AF_THRESH[addr_width:0];
  localparam logic [addr_width:0] AE_LVL = AE_THRESH[addr_width:0];

  logic almost_full_q, almost_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= AF_LVL);
      almost_empty_q <= (count_d <= AE_LVL);
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^{AF_THRESH, AE_THRESH};
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed vector table, hand sequences and
// randomized traffic against a queue-based occupancy model.
module tb_fifo_ctrl;

  localparam int AW        = 4;
  localparam int DEPTH     = 1 << AW;
  localparam int AF_THRESH = 12;
  localparam int AE_THRESH = 2;

  logic          clk;
  logic          reset;
  logic          wr;
  logic          rd;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW-1:0] r_addr;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  fifo_ctrl #(
    .addr_width(AW),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .rd       (rd),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    .almost_full (almost_full),
    .almost_empty(almost_empty)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / reference model: each queued entry is the slot address it was written to.
  logic [AW-1:0] exp_q[$];
  int            wr_total;
  int            rd_total;
  logic          ovf_m;
  logic          unf_m;
  int            checks;
  int            failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wr_total = 0;
    rd_total = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = exp_q.size();
    check({tag, ":count"},     32'(count),     32'(sz));
    check({tag, ":w_addr"},    32'(w_addr),    32'(wr_total % DEPTH));
    check({tag, ":r_addr"},    32'(r_addr),    32'(rd_total % DEPTH));
    check({tag, ":full"},      32'(full),      32'(sz == DEPTH));
    check({tag, ":empty"},     32'(empty),     32'(sz == 0));
    check({tag, ":overflow"},  32'(overflow),  32'(ovf_m));
    check({tag, ":underflow"}, 32'(underflow), 32'(unf_m));
`ifdef FIFO_ALMOST_FLAGS_EN
    check({tag, ":almost_full"},  32'(almost_full),  32'(sz >= AF_THRESH));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'(sz <= AE_THRESH));
`endif
  endtask

  // Driver: apply one request pair, check w_en and head slot, advance one edge, check state.
  task automatic step(input logic w, input logic r, input string tag);
    int   sz;
    logic is_full, is_empty, exp_wen;
    wr = w;
    rd = r;
    #1;
    sz       = exp_q.size();
    is_full  = (sz == DEPTH);
    is_empty = (sz == 0);
    exp_wen  = w && (!is_full || r);
    check({tag, ":w_en"}, 32'(w_en), 32'(exp_wen));
    if (r && !is_empty) begin
      check({tag, ":head_slot"}, 32'(r_addr), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      rd_total++;
    end
    if (exp_wen) begin
      exp_q.push_back(AW'(wr_total % DEPTH));
      wr_total++;
    end
    if (w && is_full && !r) ovf_m = 1'b1;
    if (r && is_empty)      unf_m = 1'b1;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input logic w, input logic r, input string tag);
    reset = 1'b1;
    wr    = w;
    rd    = r;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    model_reset();
    check_state(tag);
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic        exp_wen;
    logic [AW:0] exp_count;
    int          exp_waddr;
    int          exp_raddr;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    reset    = 1'b1;
    wr       = 1'b0;
    rd       = 1'b0;
    checks   = 0;
    failures = 0;
    model_reset();

    // Hand-derived vectors starting from reset: underflow, 11-while-empty, mixed traffic.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd2, 2, 0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 5'd2, 3, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 5'd1, 3, 2, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 5'd0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 5'd0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 5'd0, 3, 3, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_state("reset");

    for (int i = 0; i < 8; i++) begin
      wr = vecs[i].wr;
      rd = vecs[i].rd;
      #1;
      check($sformatf("vec%0d:w_en", i), 32'(w_en), 32'(vecs[i].exp_wen));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d:count", i),     32'(count),     32'(vecs[i].exp_count));
      check($sformatf("vec%0d:w_addr", i),    32'(w_addr),    32'(vecs[i].exp_waddr));
      check($sformatf("vec%0d:r_addr", i),    32'(r_addr),    32'(vecs[i].exp_raddr));
      check($sformatf("vec%0d:full", i),      32'(full),      32'(vecs[i].exp_full));
      check($sformatf("vec%0d:empty", i),     32'(empty),     32'(vecs[i].exp_empty));
      check($sformatf("vec%0d:overflow", i),  32'(overflow),  32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d:underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
    end

    // Fill to full; pointer wraps to 0 on the 16th write.
    do_reset(1'b0, 1'b0, "rst_fill");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, $sformatf("fill%0d", i));
    check("fill:full_const",   32'(full),   32'd1);
    check("fill:count_const",  32'(count),  32'(DEPTH));
    check("fill:w_addr_wrap",  32'(w_addr), 32'd0);

    // Write while full is rejected; simultaneous read+write while full proceeds.
    step(1'b1, 1'b0, "ovf");
    check("ovf:flag_const", 32'(overflow), 32'd1);
    step(1'b1, 1'b1, "full_rw");
    check("full_rw:full_const", 32'(full),   32'd1);
    check("full_rw:r_addr",     32'(r_addr), 32'd1);
    check("full_rw:w_addr",     32'(w_addr), 32'd1);

    // Three-in/three-out bursts walking the pointers around the ring.
    do_reset(1'b0, 1'b0, "rst_burst");
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $sformatf("bw%0d", b));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $sformatf("br%0d", b));
      check($sformatf("burst%0d:empty_const", b), 32'(empty), 32'd1);
    end
    check("burst:r_addr_const", 32'(r_addr), 32'(30 % DEPTH));

    // Reset with a concurrent write discards contents and sticky flags.
    step(1'b0, 1'b1, "pre_unf");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "pre_rst");
    do_reset(1'b1, 1'b0, "mid_rst");
    check("mid_rst:count_const",     32'(count),     32'd0);
    check("mid_rst:underflow_const", 32'(underflow), 32'd0);

    // Threshold walk: 12 writes then 10 reads.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "thr_w");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "thr_r");

    // Randomized traffic with phase-varying bias so both full and empty are visited.
    for (int n = 0; n < 2000; n++) begin
      int wb;
      int rb;
      wb = ((n / 150) % 2 == 0) ? 75 : 25;
      rb = 100 - wb;
      if ($urandom_range(0, 199) == 0)
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd_rst");
      else
        step(1'($urandom_range(0, 99) < wb), 1'($urandom_range(0, 99) < rb), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
